// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap stage: 256 iterations of j += S[i] + key[i mod KEY_BYTES], swap S[i]/S[j].
// Optional build macro KSA_SAME_INDEX_SKIP_EN: iterations with j == i skip the read/swap of S[j].
module ksa_shuffle #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_shuffle,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [DATA_W-1:0]      read_data,
  output logic [ADDR_W-1:0]      address_shuffle,
  output logic [DATA_W-1:0]      write_data_shuffle,
  output logic                   write_enable_shuffle,
  output logic                   finish_shuffle
);

  localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d, j_q, j_d, j_new;
  logic [KI_W-1:0]     key_idx_q, key_idx_d;
  logic [DATA_W-1:0]   si_q, si_d, sj_q, sj_d, j_sum;
  logic                start_q;

  // Byte 0 of the key sits in the most significant byte of secret_key.
  function automatic logic [7:0] key_byte(input logic [KI_W-1:0] idx);
    logic [7:0] kb;
    kb = 8'd0;
    for (int k = 0; k < KEY_BYTES; k++)
      if (idx == KI_W'(k)) kb = secret_key[8*(KEY_BYTES-1-k) +: 8];
    return kb;
  endfunction

  assign j_sum = DATA_W'(j_q) + read_data + DATA_W'(key_byte(key_idx_q));
  assign j_new = ADDR_W'(j_sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      key_idx_q <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      key_idx_q <= key_idx_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      start_q   <= start_shuffle;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    key_idx_d = key_idx_q;
    si_d      = si_q;
    sj_d      = sj_q;
    case (state_q)
      IDLE: begin
        if (start_shuffle && !start_q) begin
          i_d       = '0;
          j_d       = '0;
          key_idx_d = '0;
          state_d   = RD_I;
        end
      end
      RD_I:  state_d = CAP_I;
      CAP_I: begin
        si_d = read_data;
        j_d  = j_new;
`ifdef KSA_SAME_INDEX_SKIP_EN
        state_d = (j_new == i_q) ? NEXT : RD_J;
`else
        state_d = RD_J;
`endif
      end
      RD_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = read_data;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J:  state_d = NEXT;
      NEXT: begin
        if (i_q == '1) begin
          state_d = DONE;
        end else begin
          i_d       = i_q + ADDR_W'(1);
          key_idx_d = (key_idx_q == KI_W'(KEY_BYTES-1)) ? '0 : key_idx_q + KI_W'(1);
          state_d   = RD_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    address_shuffle      = '0;
    write_data_shuffle   = '0;
    write_enable_shuffle = 1'b0;
    finish_shuffle       = 1'b0;
    case (state_q)
      RD_I, CAP_I: address_shuffle = i_q;
      RD_J, CAP_J: address_shuffle = j_q;
      WR_I: begin
        address_shuffle      = i_q;
        write_data_shuffle   = sj_q;
        write_enable_shuffle = 1'b1;
      end
      WR_J: begin
        address_shuffle      = j_q;
        write_data_shuffle   = si_q;
        write_enable_shuffle = 1'b1;
      end
      DONE:    finish_shuffle = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: single-port S-memory model, software KSA scoreboard, table vectors.
module tb_ksa_shuffle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_shuffle = 1'b0;
  logic [23:0] secret_key = 24'h0;
  logic [7:0]  read_data = 8'h0;
  logic [7:0]  address_shuffle, write_data_shuffle;
  logic        write_enable_shuffle, finish_shuffle;

  ksa_shuffle #(.KEY_BYTES(3), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start_shuffle(start_shuffle), .secret_key(secret_key),
    .read_data(read_data), .address_shuffle(address_shuffle),
    .write_data_shuffle(write_data_shuffle), .write_enable_shuffle(write_enable_shuffle),
    .finish_shuffle(finish_shuffle)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       init_req = 1'b0;

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (write_enable_shuffle) begin
      mem[address_shuffle] <= write_data_shuffle;
    end
    read_data <= mem[address_shuffle];
  end

  typedef struct { int a; int d; int cyc; } wr_t;
  typedef struct { logic [23:0] key; int pair; int a0; int d0; int a1; int d1; } vec_t;

  wr_t        exp_q[$];
  wr_t        log_q[$];
  vec_t       vecs[$];
  logic [7:0] model_s [256];
  int         addr_trace [2200];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         sb_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next write of the software model.
  always @(negedge clk) begin
    if (sb_en && write_enable_shuffle) begin
      wr_t w, e;
      w.a = int'(address_shuffle); w.d = int'(write_data_shuffle); w.cyc = cyc;
      log_q.push_back(w);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", w.a, -1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", w.a, e.a);
        check("wr_data", w.d, e.d);
      end
    end
  end

  task automatic init_mem();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  task automatic build_expected(input logic [23:0] key, output int skips);
    int j, kidx;
    logic [7:0] t, kb;
    wr_t w;
    j = 0; kidx = 0; skips = 0;
    exp_q.delete();
    for (int k = 0; k < 256; k++) model_s[k] = mem[k];
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(2-kidx) +: 8];
      j = (j + int'(model_s[i]) + int'(kb)) % 256;
`ifdef KSA_SAME_INDEX_SKIP_EN
      if (j == i) skips++;
      else
`endif
      begin
        w.a = i; w.d = int'(model_s[j]); w.cyc = 0; exp_q.push_back(w);
        w.a = j; w.d = int'(model_s[i]); exp_q.push_back(w);
        t = model_s[i]; model_s[i] = model_s[j]; model_s[j] = t;
      end
      kidx = (kidx == 2) ? 0 : kidx + 1;
    end
  endtask

  task automatic run(input logic [23:0] key, input bit hold, output int skips);
    int fin_cyc, fin_cnt, nmis, ndist;
    bit seen [256];
    secret_key = key;
    build_expected(key, skips);
    log_q.delete();
    sb_en = 1'b1;
    fin_cyc = -1; fin_cnt = 0;
    @(negedge clk) start_shuffle = 1'b1;
    for (int c = 0; c < 2150; c++) begin
      @(posedge clk); #1;
      cyc = c;
      addr_trace[c] = int'(address_shuffle);
      if (!hold && c == 0) start_shuffle = 1'b0;
      if (hold && c == 498) start_shuffle = 1'b0;
      if (hold && c == 499) start_shuffle = 1'b1;
      if (finish_shuffle) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = c;
      end
      if (fin_cyc >= 0 && c >= fin_cyc + (hold ? 20 : 3)) break;
    end
    start_shuffle = 1'b0;
    check("finish_latency", fin_cyc, 1792 - 4*skips);
    check("finish_pulses", fin_cnt, 1);
    check("write_count", log_q.size(), 512 - 2*skips);
    check("scoreboard_left", exp_q.size(), 0);
    nmis = 0; ndist = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== model_s[k]) nmis++;
      if (!seen[mem[k]]) ndist++;
      seen[mem[k]] = 1'b1;
    end
    check("final_mem_mismatch", nmis, 0);
    check("final_mem_distinct", ndist, 256);
  endtask

  initial begin
    int skips, n, idle_act;
    // Reset state
    #2;
    check("rst_addr", int'(address_shuffle), 0);
    check("rst_we", int'(write_enable_shuffle), 0);
    check("rst_data", int'(write_data_shuffle), 0);
    check("rst_finish", int'(finish_shuffle), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

`ifdef KSA_SAME_INDEX_SKIP_EN
    vecs.push_back('{24'h000000, 0, 2, 3, 3, 2});
    vecs.push_back('{24'h000249, 0, 1, 3, 3, 1});
`else
    vecs.push_back('{24'h000000, 0, 0, 0, 0, 0});
    vecs.push_back('{24'h000000, 2, 2, 3, 3, 2});
    vecs.push_back('{24'h000249, 1, 1, 3, 3, 1});
    vecs.push_back('{24'h000249, 0, 0, 0, 0, 0});
`endif
    foreach (vecs[v]) begin
      init_mem();
      run(vecs[v].key, 1'b0, skips);
      n = 2 * vecs[v].pair;
      check("vec_pair_present", int'(log_q.size() > n + 1), 1);
      if (log_q.size() > n + 1) begin
        check("vec_a0", log_q[n].a, vecs[v].a0);
        check("vec_d0", log_q[n].d, vecs[v].d0);
        check("vec_a1", log_q[n+1].a, vecs[v].a1);
        check("vec_d1", log_q[n+1].d, vecs[v].d1);
      end
    end

    // Early-iteration timing with key 0 (i=0 and i=1 have j == i)
    init_mem();
    run(24'h000000, 1'b0, skips);
    n = 0;
    foreach (log_q[k]) if (log_q[k].cyc < 14) n++;
`ifdef KSA_SAME_INDEX_SKIP_EN
    check("skip_writes_i01", n, 0);
    check("skip_rd_addr2_cyc7", addr_trace[6], 2);
    check("skip_count_key0", skips, 2);
`else
    check("writes_i01", n, 4);
    check("rd_addr1_cyc8", addr_trace[7], 1);
    check("rd_addr2_cyc15", addr_trace[14], 2);
`endif

    // Full run, key 1
    init_mem();
    run(24'h000001, 1'b0, skips);

    // Reset during iteration 100
    init_mem();
    secret_key = 24'h000001;
    build_expected(24'h000001, skips);
    sb_en = 1'b1;
    @(negedge clk) start_shuffle = 1'b1;
    @(posedge clk); #1 start_shuffle = 1'b0;
    n = 1;
    while (n < 4000 && !(write_enable_shuffle == 1'b0 && address_shuffle == 8'd100 && n > 700)) begin
      @(posedge clk); #1; n++;
    end
    check("reached_iter100", int'(address_shuffle), 100);
    sb_en = 1'b0;
    exp_q.delete();
    #1 reset = 1'b0;
    #1;
    check("midrst_addr", int'(address_shuffle), 0);
    check("midrst_we", int'(write_enable_shuffle), 0);
    check("midrst_data", int'(write_data_shuffle), 0);
    check("midrst_finish", int'(finish_shuffle), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_act = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (write_enable_shuffle || finish_shuffle || address_shuffle != 8'd0) idle_act++;
    end
    check("post_reset_idle", idle_act, 0);
    run(24'h000001, 1'b0, skips);
    check("restart_addr_cap_i", addr_trace[1], 0);

    // Start held high through the run, with a spurious edge mid-run
    init_mem();
    run(24'h000249, 1'b1, skips);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ksa_shuffle.md
Name: ksa_shuffle

Overview:
- RC4 key-scheduling (KSA) swap stage. Runs after the S-memory init stage has written S[k]=k.
- Performs 256 iterations: j = j + S[i] + key[i mod KEY_BYTES], then swaps S[i] and S[j].
- Drives the shuffle-side address, write-data and write-enable inputs of state_machine_control. Reads S through the same address, using the shared single-port RAM's read data.
- Consumes start_shuffle and returns finish_shuffle.

Parameters:
- KEY_BYTES, 3, number of secret key bytes; key index wraps at KEY_BYTES-1.
- ADDR_W, 8, S-memory address width; indices i, j and the iteration count wrap mod 2^ADDR_W.
- DATA_W, 8, S-memory data width; all sums are mod 2^DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- start_shuffle  in  1  start request from control; rising edge starts a run.
- secret_key  in  KEY_BYTES*8  key; byte k = secret_key[8*(KEY_BYTES-1-k) +: 8] (byte 0 = MSB).
- read_data  in  DATA_W  S-memory q; valid in the cycle after the address is presented.
- address_shuffle  out  ADDR_W  S-memory address (read and write).
- write_data_shuffle  out  DATA_W  S-memory write data.
- write_enable_shuffle  out  1  S-memory write strobe.
- finish_shuffle  out  1  one-cycle done pulse.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE; i, j, key_idx, si, sj and start_q = 0.
  - All outputs 0.
- Output timing: all outputs are decoded from the state and internal flops only. There is no combinational path from any input to any output.
- Start detect: start_q registers start_shuffle each cycle. A run begins only in IDLE, when start_shuffle=1 and start_q=0.
  - start_shuffle held high does not retrigger.
  - start_shuffle edges outside IDLE are ignored.
- States (one cycle each unless noted):
  - IDLE: outputs 0. On a start edge: i=0, j=0, key_idx=0, go to RD_I.
  - RD_I: address=i, we=0.
  - CAP_I: address=i. Latch si=read_data and j = j + read_data + key[key_idx] (mod 256).
  - RD_J: address=j (new value), we=0.
  - CAP_J: address=j. Latch sj=read_data.
  - WR_I: address=i, data=sj, we=1.
  - WR_J: address=j, data=si, we=1.
  - NEXT: we=0. If i==255 go to DONE. Otherwise i=i+1, key_idx = (key_idx==KEY_BYTES-1) ? 0 : key_idx+1, and go to RD_I.
  - DONE: finish_shuffle=1 for exactly one cycle, then IDLE.
- Latency:
  - 7 cycles per iteration, 1792 cycles per run.
  - Counting the edge that samples the start edge as edge 0, the edge 1792 enters DONE and finish_shuffle is high for the following cycle.
- Case i==j: both writes occur at the same address with the same value (si==sj). Final contents are correct.
- write_data_shuffle is 0 in every state other than WR_I and WR_J.
- Reset mid-run:
  - Immediate return to IDLE with outputs 0.
  - Partially swapped memory is not restored; re-init is control's responsibility.
  - A new start edge restarts from i=0, j=0.
- secret_key must be stable for the whole run; it is sampled every CAP_I.

Optional Feature:
- Macro: KSA_SAME_INDEX_SKIP_EN.
- Defined: in CAP_I, if the newly computed j equals i, go directly to NEXT.
  - RD_J, CAP_J, WR_I and WR_J are skipped; that iteration takes 3 cycles and issues no write.
  - Run latency becomes data-dependent: 1792 minus 4 per skipped iteration.
- Undefined: fixed 7-cycle iterations as above; writes occur even when i==j.

Test Plan:
- Identity S (S[k]=k), key=24'h000000, start edge:
  - Iteration i=0: writes addr0←0, addr0←0.
  - Iteration i=2 (j=3): writes addr2←3, then addr3←2.
- Identity S, key=24'h000249:
  - Iteration i=1 computes j=3 and writes addr1←3, addr3←1.
  - Iteration i=0 writes addr0←0 twice.
- Identity S, key=24'h000001, full run:
  - Final memory matches a software KSA model and is a permutation of 0..255.
  - finish_shuffle is high for exactly 1 cycle, 1792 edges after the start-sample edge.
- Assert reset=0 during iteration i=100:
  - All outputs read 0 before the next clock edge.
  - After release, no activity until a fresh 0→1 on start_shuffle; the run then restarts at address 0.
- Hold start_shuffle=1 from the start through 20 cycles after finish:
  - Exactly one run occurs and exactly one finish pulse is seen.
  - A 0→1 pulse on start_shuffle at cycle 500 is ignored.
- With KSA_SAME_INDEX_SKIP_EN, identity S, key=24'h000000:
  - Iterations i=0 and i=1 produce no write_enable_shuffle pulses.
  - Iteration i=2 first drives read address 2 on cycle 7 after start.
  - Without the macro, the same stimulus shows 4 write pulses for i=0..1.
